instruction_fetch: RTL and testbench

Instruction-fetch stage of the pipelined MIPS core. It sits directly upstream of the instruction ROM: it drives the word address, takes the returned instruction word, and registers it into the IF/ID pipeline register. It owns the PC, the kernel/user bit (PC[31]), vector dispatch for reset, interrupt and exception, and stall/flush/redirect handling from downstream stages.

---
 rtl/instruction_fetch_pkg.sv | 27 ++
 rtl/instruction_fetch_pc_select.sv | 64 ++++++
 rtl/instruction_fetch.sv | 122 ++++++++++++
 tb/tb_instruction_fetch.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg
// Shared constants and types for the instruction-fetch stage: default vector
// addresses, the bubble instruction word, the next-PC select encoding and the
// sequential-PC helper that keeps the kernel bit out of the increment.
package instruction_fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] DEFAULT_IRQ_VEC   = 32'h8000_0004;
    localparam logic [31:0] DEFAULT_EXC_VEC   = 32'h8000_0008;
    localparam logic [31:0] DEFAULT_NOP_WORD  = 32'h0000_0000;

    // Next-PC source, listed lowest to highest priority.
    typedef enum logic [2:0] {
        SEL_SEQ   = 3'd0,
        SEL_HOLD  = 3'd1,
        SEL_REDIR = 3'd2,
        SEL_IRQ   = 3'd3,
        SEL_EXC   = 3'd4
    } pc_sel_t;

    // Bit 31 is the kernel/user bit; only the low 31 bits count and they wrap
    // modulo 2^31, so falling through never changes the mode.
    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

endpackage

// File: rtl/instruction_fetch_pc_select.sv
// pc_select
// Combinational next-PC priority encoder and mux.
// Ports:
//   pc              current PC
//   stall           hold request from the hazard unit
//   redirect        taken branch/jump from a later stage
//   redirect_target raw target byte address
//   redirect_is_jr  register jump: bit 31 of the target is honoured
//   irq, exc        interrupt level / exception request
//   sel             chosen next-PC source
//   next_pc         PC value for the next cycle
//   redirect_pc     effective (aligned, mode-adjusted) redirect target
module pc_select
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] IRQ_VEC = DEFAULT_IRQ_VEC,
    parameter logic [31:0] EXC_VEC = DEFAULT_EXC_VEC
) (
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        redirect_is_jr,
    input  logic        irq,
    input  logic        exc,
    output pc_sel_t     sel,
    output logic [31:0] next_pc,
    output logic [31:0] redirect_pc
);

    logic [31:0] aligned_target;

    always_comb begin
        // NOTE: every output gets a default first so no path through this block
        // leaves a value unassigned, which would otherwise infer a latch.
        sel            = SEL_SEQ;
        next_pc        = seq_pc(pc);
        aligned_target = redirect_target & 32'hFFFF_FFFC;

        // Plain branches stay in the current mode; only jr may switch it.
        redirect_pc = {redirect_is_jr ? aligned_target[31] : pc[31], aligned_target[30:0]};

        // Interrupts are masked in kernel mode and deferred while stalled;
        // the request is level-sensitive so it is picked up later.
        if (exc) begin
            sel = SEL_EXC;
        end else if (irq && !pc[31] && !stall) begin
            sel = SEL_IRQ;
        end else if (redirect) begin
            sel = SEL_REDIR;
        end else if (stall) begin
            sel = SEL_HOLD;
        end

        case (sel)
            SEL_EXC:   next_pc = EXC_VEC;
            SEL_IRQ:   next_pc = IRQ_VEC;
            SEL_REDIR: next_pc = redirect_pc;
            SEL_HOLD:  next_pc = pc;
            default:   next_pc = seq_pc(pc);
        endcase
    end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch
// IF stage of the pipelined MIPS core. Owns the PC (bit 31 = kernel mode),
// drives the instruction ROM address, and registers the returned word into
// the IF/ID pipeline register. Handles reset/irq/exception vectoring,
// stall, flush and redirects from later stages.
// Ports:
//   clk, reset        core clock; synchronous active-low reset
//   imem_addr         byte address to ROM (= PC)
//   imem_data         combinational instruction word from ROM
//   stall, flush      hold everything / squash IF/ID
//   redirect*         taken branch/jump and its target
//   irq, exc          interrupt level / exception request
//   if_id_*           IF/ID register: instruction, its PC+4, valid
//   epc_valid, epc    one-cycle write strobe and resume address for $26
//   kernel_mode       PC[31]
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC,
    parameter logic [31:0] IRQ_VEC   = DEFAULT_IRQ_VEC,
    parameter logic [31:0] EXC_VEC   = DEFAULT_EXC_VEC,
    parameter logic [31:0] NOP_WORD  = DEFAULT_NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        redirect_is_jr,
    input  logic        irq,
    input  logic        exc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        epc_valid,
    output logic [31:0] epc,
    output logic        kernel_mode
);

    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] redirect_pc;
    pc_sel_t     sel;

    pc_select #(
        .IRQ_VEC (IRQ_VEC),
        .EXC_VEC (EXC_VEC)
    ) u_pc_select (
        .pc              (pc),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .redirect_is_jr  (redirect_is_jr),
        .irq             (irq),
        .exc             (exc),
        .sel             (sel),
        .next_pc         (next_pc),
        .redirect_pc     (redirect_pc)
    );

    assign imem_addr   = pc;
    assign kernel_mode = pc[31];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; reset is checked first inside the clocked
    // block so it overrides any concurrent stall/redirect.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc             <= RESET_VEC;
            if_id_instr    <= NOP_WORD;
            if_id_pc_plus4 <= 32'h0;
            if_id_valid    <= 1'b0;
            epc_valid      <= 1'b0;
            epc            <= 32'h0;
        end else begin
            pc        <= next_pc;
            epc_valid <= 1'b0;

            // A bubble leaves if_id_pc_plus4 at its previous value.
            case (sel)
                SEL_EXC: begin
                    if_id_instr <= NOP_WORD;
                    if_id_valid <= 1'b0;
                    epc         <= redirect ? redirect_target : pc;
                    epc_valid   <= 1'b1;
                end
                SEL_IRQ: begin
                    // Resume at the instruction that has not issued yet.
                    if_id_instr <= NOP_WORD;
                    if_id_valid <= 1'b0;
                    epc         <= redirect ? redirect_pc : pc;
                    epc_valid   <= 1'b1;
                end
                SEL_REDIR: begin
                    if_id_instr <= NOP_WORD;
                    if_id_valid <= 1'b0;
                end
                SEL_HOLD: begin
                    // A squash still kills the held instruction.
                    if (flush) begin
                        if_id_instr <= NOP_WORD;
                        if_id_valid <= 1'b0;
                    end
                end
                default: begin
                    if (flush) begin
                        if_id_instr <= NOP_WORD;
                        if_id_valid <= 1'b0;
                    end else begin
                        if_id_instr    <= imem_data;
                        if_id_pc_plus4 <= next_pc;
                        if_id_valid    <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall, flush, redirect, redirect_is_jr, irq, exc;
    logic [31:0] redirect_target;
    logic [31:0] if_id_instr, if_id_pc_plus4, epc;
    logic        if_id_valid, epc_valid, kernel_mode;

    int checks = 0;
    int errors = 0;

    logic [31:0] rom [256];
    assign imem_data = rom[imem_addr[9:2]];

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk             (clk),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .stall           (stall),
        .flush           (flush),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .redirect_is_jr  (redirect_is_jr),
        .irq             (irq),
        .exc             (exc),
        .if_id_instr     (if_id_instr),
        .if_id_pc_plus4  (if_id_pc_plus4),
        .if_id_valid     (if_id_valid),
        .epc_valid       (epc_valid),
        .epc             (epc),
        .kernel_mode     (kernel_mode)
    );

    // Reference model state: architectural view of PC, IF/ID and EPC.
    logic [31:0] m_pc, m_instr, m_pc4, m_epc;
    logic        m_valid, m_epcv;

    // Advance the model by one clock from the current inputs, then clock the DUT.
    task automatic tick();
        logic [31:0] n_pc, n_instr, n_pc4, n_epc, seq, eff;
        logic        n_valid, n_epcv;
        logic        bubble;
        n_pc = m_pc; n_instr = m_instr; n_pc4 = m_pc4; n_epc = m_epc;
        n_valid = m_valid; n_epcv = 1'b0; bubble = 1'b0;
        seq = {m_pc[31], 31'((m_pc[30:0] + 31'd4) % 32'h8000_0000)};
        eff = {redirect_is_jr ? redirect_target[31] : m_pc[31], redirect_target[30:2], 2'b00};
        if (!reset) begin
            n_pc = 32'h8000_0000; n_instr = 32'h0; n_pc4 = 32'h0;
            n_valid = 1'b0; n_epc = 32'h0;
        end else if (exc) begin
            n_pc = 32'h8000_0008; bubble = 1'b1; n_epcv = 1'b1;
            n_epc = redirect ? redirect_target : m_pc;
        end else if (irq && m_pc[31] == 1'b0 && !stall) begin
            n_pc = 32'h8000_0004; bubble = 1'b1; n_epcv = 1'b1;
            n_epc = redirect ? eff : m_pc;
        end else if (redirect) begin
            n_pc = eff; bubble = 1'b1;
        end else if (stall) begin
            bubble = flush;
        end else begin
            n_pc = seq;
            if (flush) bubble = 1'b1;
            else begin
                n_instr = rom[m_pc[9:2]]; n_pc4 = seq; n_valid = 1'b1;
            end
        end
        if (bubble) begin
            n_instr = 32'h0; n_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_instr = n_instr; m_pc4 = n_pc4; m_epc = n_epc;
        m_valid = n_valid; m_epcv = n_epcv;
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; redirect = 0; redirect_target = 32'h0;
        redirect_is_jr = 0; irq = 0; exc = 0;
    endtask

    task automatic test_reset();
        reset = 0; idle_inputs();
        tick(); tick();
        checks += 6;
        if (imem_addr !== 32'h8000_0000) begin errors++; $display("FAIL reset_pc got %h exp %h", imem_addr, 32'h8000_0000); end
        if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", if_id_valid); end
        if (if_id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", if_id_instr); end
        if (if_id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got %h exp 0", if_id_pc_plus4); end
        if (epc_valid !== 1'b0 || epc !== 32'h0) begin errors++; $display("FAIL reset_epc got %b/%h exp 0/0", epc_valid, epc); end
        if (kernel_mode !== 1'b1) begin errors++; $display("FAIL reset_kernel got %b exp 1", kernel_mode); end
        reset = 1;
        tick();
        checks += 3;
        if (if_id_valid !== 1'b1 || if_id_pc_plus4 !== 32'h8000_0004) begin
            errors++; $display("FAIL first_fetch got v=%b pc4=%h exp v=1 pc4=80000004", if_id_valid, if_id_pc_plus4);
        end
        if (if_id_instr !== rom[0]) begin errors++; $display("FAIL first_instr got %h exp %h", if_id_instr, rom[0]); end
        if (imem_addr !== 32'h8000_0004) begin errors++; $display("FAIL seq_pc1 got %h exp 80000004", imem_addr); end
        tick();
        checks++;
        if (imem_addr !== 32'h8000_0008) begin errors++; $display("FAIL seq_pc2 got %h exp 80000008", imem_addr); end
    endtask

    task automatic test_stall();
        tick(); tick();
        checks++;
        if (imem_addr !== 32'h8000_0010) begin errors++; $display("FAIL stall_setup got %h exp 80000010", imem_addr); end
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (imem_addr !== 32'h8000_0010 || if_id_pc_plus4 !== 32'h8000_0010 ||
                if_id_valid !== 1'b1 || if_id_instr !== rom[3]) begin
                errors++;
                $display("FAIL stall_hold[%0d] got pc=%h pc4=%h v=%b i=%h exp pc=80000010 pc4=80000010 v=1 i=%h",
                         i, imem_addr, if_id_pc_plus4, if_id_valid, if_id_instr, rom[3]);
            end
        end
        stall = 0;
        tick();
        checks++;
        if (imem_addr !== 32'h8000_0014 || if_id_pc_plus4 !== 32'h8000_0014) begin
            errors++; $display("FAIL stall_release got pc=%h pc4=%h exp 80000014/80000014", imem_addr, if_id_pc_plus4);
        end
    endtask

    task automatic test_redirect();
        tick(); tick(); tick();
        redirect = 1; redirect_target = 32'h0000_0040; redirect_is_jr = 0;
        tick();
        checks++;
        if (imem_addr !== 32'h8000_0040 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin
            errors++; $display("FAIL branch got pc=%h v=%b i=%h exp 80000040/0/0", imem_addr, if_id_valid, if_id_instr);
        end
        redirect_target = 32'h0000_000C; redirect_is_jr = 1;
        tick();
        checks++;
        if (imem_addr !== 32'h0000_000C || kernel_mode !== 1'b0 || if_id_valid !== 1'b0) begin
            errors++; $display("FAIL jr_user got pc=%h k=%b v=%b exp 0000000c/0/0", imem_addr, kernel_mode, if_id_valid);
        end
        idle_inputs();
    endtask

    task automatic test_irq();
        redirect = 1; redirect_target = 32'h0000_0100; redirect_is_jr = 1;
        tick();
        idle_inputs();
        irq = 1;
        tick();
        checks++;
        if (imem_addr !== 32'h8000_0004 || epc !== 32'h0000_0100 || epc_valid !== 1'b1 || if_id_valid !== 1'b0) begin
            errors++; $display("FAIL irq_take got pc=%h epc=%h ev=%b v=%b exp 80000004/00000100/1/0",
                               imem_addr, epc, epc_valid, if_id_valid);
        end
        tick();
        checks++;
        if (imem_addr !== 32'h8000_0008 || epc_valid !== 1'b0) begin
            errors++; $display("FAIL irq_masked got pc=%h ev=%b exp 80000008/0", imem_addr, epc_valid);
        end
        tick();
        checks++;
        if (imem_addr !== 32'h8000_000C || epc_valid !== 1'b0) begin
            errors++; $display("FAIL irq_masked2 got pc=%h ev=%b exp 8000000c/0", imem_addr, epc_valid);
        end
        irq = 0;
    endtask

    task automatic test_irq_stall();
        redirect = 1; redirect_target = 32'h0000_0200; redirect_is_jr = 1;
        tick();
        idle_inputs();
        stall = 1; irq = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (imem_addr !== 32'h0000_0200 || epc_valid !== 1'b0) begin
                errors++; $display("FAIL irq_deferred[%0d] got pc=%h ev=%b exp 00000200/0", i, imem_addr, epc_valid);
            end
        end
        stall = 0;
        tick();
        checks++;
        if (imem_addr !== 32'h8000_0004 || epc !== 32'h0000_0200 || epc_valid !== 1'b1) begin
            errors++; $display("FAIL irq_after_stall got pc=%h epc=%h ev=%b exp 80000004/00000200/1", imem_addr, epc, epc_valid);
        end
        irq = 0;
    endtask

    task automatic test_exc_reset();
        stall = 1; exc = 1; redirect = 1; redirect_target = 32'h0000_0200; redirect_is_jr = 0;
        tick();
        checks++;
        if (imem_addr !== 32'h8000_0008 || epc !== 32'h0000_0200 || epc_valid !== 1'b1 || if_id_valid !== 1'b0) begin
            errors++; $display("FAIL exc_take got pc=%h epc=%h ev=%b v=%b exp 80000008/00000200/1/0",
                               imem_addr, epc, epc_valid, if_id_valid);
        end
        idle_inputs();
        stall = 1; redirect = 1; redirect_target = 32'h0000_0444;
        reset = 0;
        tick();
        checks++;
        if (imem_addr !== 32'h8000_0000 || if_id_instr !== 32'h0 || if_id_pc_plus4 !== 32'h0 ||
            if_id_valid !== 1'b0 || epc_valid !== 1'b0 || epc !== 32'h0) begin
            errors++; $display("FAIL reset_override got pc=%h i=%h pc4=%h v=%b ev=%b epc=%h exp all reset values",
                               imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid, epc_valid, epc);
        end
        idle_inputs();
        reset = 1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            reset           = ($urandom_range(0, 40) != 0);
            exc             = ($urandom_range(0, 15) == 0);
            irq             = ($urandom_range(0, 3) == 0);
            redirect        = ($urandom_range(0, 4) == 0);
            stall           = ($urandom_range(0, 3) == 0);
            flush           = stall ? 1'b0 : ($urandom_range(0, 5) == 0);
            redirect_is_jr  = $urandom_range(0, 1) == 1;
            redirect_target = $urandom;
            tick();
            checks++;
            if (imem_addr !== m_pc || kernel_mode !== m_pc[31]) begin
                errors++; $display("FAIL rand_pc[%0d] got %h k=%b exp %h", n, imem_addr, kernel_mode, m_pc);
            end
            checks++;
            if (if_id_instr !== m_instr || if_id_valid !== m_valid || if_id_pc_plus4 !== m_pc4) begin
                errors++; $display("FAIL rand_ifid[%0d] got i=%h v=%b pc4=%h exp i=%h v=%b pc4=%h",
                                   n, if_id_instr, if_id_valid, if_id_pc_plus4, m_instr, m_valid, m_pc4);
            end
            checks++;
            if (epc !== m_epc || epc_valid !== m_epcv) begin
                errors++; $display("FAIL rand_epc[%0d] got %h/%b exp %h/%b", n, epc, epc_valid, m_epc, m_epcv);
            end
        end
        idle_inputs();
        reset = 1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
        test_reset();
        test_stall();
        test_redirect();
        test_irq();
        test_irq_stall();
        test_exc_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
